// File: rtl/wire_bomb_pkg.sv
// Shared types and constants for the wire-cutting puzzle controller.
package wire_bomb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    DEFUSED  = 2'd2,
    EXPLODED = 2'd3
  } state_t;

  localparam int SECONDS_W = 8;
  localparam int STRIKES_W = 2;
  localparam logic [2:0] DEFAULT_TARGET_MASK = 3'b101;

  function automatic logic [SECONDS_W-1:0] sat_sub(input logic [SECONDS_W-1:0] a,
                                                   input int unsigned d);
    if (32'(a) > d) return SECONDS_W'(32'(a) - d);
    return '0;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// 1 Hz tick generator: down-counter that reloads on terminal count and
// pulses tick for one cycle on the wrap. clear overrides enable.
module tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RESET || clear) cnt <= LOAD;
    else if (enable)    cnt <= (cnt == '0) ? LOAD : cnt - 1'b1;
  end

  assign tick = enable && (cnt == '0);

endmodule

// File: rtl/wire_bomb_ctrl.sv
// Wire-cutting bomb game controller. Optional feature: STRIKE_TIME_PENALTY_EN
// makes every strike also remove PENALTY_S seconds from the countdown.
//   state    | meaning
//   IDLE     | waiting for start with all wires intact
//   ARMED    | countdown running, watching for cuts
//   DEFUSED  | all target wires cut; outputs frozen until start
//   EXPLODED | timeout or too many strikes; frozen until start
module wire_bomb_ctrl
  import wire_bomb_pkg::*;
#(
  parameter int         CLK_HZ       = 100_000_000,
  parameter int         TIME_LIMIT_S = 60,
  parameter int         MAX_STRIKES  = 1,
  parameter logic [2:0] TARGET_MASK  = DEFAULT_TARGET_MASK,
  parameter int         PENALTY_S    = 10
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 start,
  input  logic [2:0]           wire_cut,
  output logic [1:0]           state,
  output logic [SECONDS_W-1:0] seconds_left,
  output logic [STRIKES_W-1:0] strikes,
  output logic                 strike_pulse,
  output logic                 led_defused,
  output logic                 led_exploded
);

  localparam logic [SECONDS_W-1:0] TL_LOAD  = SECONDS_W'(TIME_LIMIT_S);
  localparam logic [STRIKES_W-1:0] STRK_MAX = STRIKES_W'(MAX_STRIKES);

  state_t               st;
  logic [2:0]           cut_mask, mask_next;
  logic [STRIKES_W-1:0] strikes_inc;
  logic [SECONDS_W-1:0] secs_next;
  logic                 tick, clear, wrong, strike_out, defuse;
  int unsigned          dec;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .CLK    (CLK),
    .RESET  (RESET),
    .clear  (clear),
    .enable (st == ARMED),
    .tick   (tick)
  );

  assign clear = start && ((st == IDLE && wire_cut == 3'b000) ||
                           st == DEFUSED || st == EXPLODED);

  always_comb begin
    mask_next   = cut_mask | wire_cut;
    wrong       = |(wire_cut & ~cut_mask & ~TARGET_MASK);
    strikes_inc = (strikes == '1) ? strikes : strikes + 1'b1;
    strike_out  = wrong && (strikes_inc >= STRK_MAX);
    defuse      = (mask_next & TARGET_MASK) == TARGET_MASK;
    dec         = tick ? 32'd1 : 32'd0;
`ifdef STRIKE_TIME_PENALTY_EN
    if (wrong) dec = dec + int unsigned'(PENALTY_S);
`endif
    secs_next   = sat_sub(seconds_left, dec);
  end

`ifndef STRIKE_TIME_PENALTY_EN
  logic unused_penalty;
  assign unused_penalty = ^PENALTY_S;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st           <= IDLE;
      seconds_left <= TL_LOAD;
      strikes      <= '0;
      strike_pulse <= 1'b0;
      led_defused  <= 1'b0;
      led_exploded <= 1'b0;
      cut_mask     <= '0;
    end else begin
      strike_pulse <= 1'b0;
      case (st)
        IDLE: begin
          if (start && wire_cut == 3'b000) begin
            st           <= ARMED;
            cut_mask     <= '0;
            strikes      <= '0;
            seconds_left <= TL_LOAD;
          end
        end
        ARMED: begin
          cut_mask     <= mask_next;
          strike_pulse <= wrong;
          if (wrong) strikes <= strikes_inc;
          // Higher-priority resolutions freeze the clock at its current value.
          if (strike_out) begin
            st           <= EXPLODED;
            led_exploded <= 1'b1;
          end else if (defuse) begin
            st          <= DEFUSED;
            led_defused <= 1'b1;
          end else begin
            seconds_left <= secs_next;
            if (secs_next == '0) begin
              st           <= EXPLODED;
              led_exploded <= 1'b1;
            end
          end
        end
        default: begin
          if (start) begin
            st           <= IDLE;
            seconds_left <= TL_LOAD;
            strikes      <= '0;
            cut_mask     <= '0;
            led_defused  <= 1'b0;
            led_exploded <= 1'b0;
          end
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_wire_bomb_ctrl.sv
// Self-checking bench for wire_bomb_ctrl: two instances (MAX_STRIKES 1 and 2)
// share stimulus and are compared against an elapsed-time reference model.
module tb_wire_bomb_ctrl;

  localparam int         CLK_HZ = 10;
  localparam int         TL     = 5;
  localparam int         PEN    = 3;
  localparam logic [2:0] TGT    = 3'b101;
`ifdef STRIKE_TIME_PENALTY_EN
  localparam int PEN_EFF = PEN;
`else
  localparam int PEN_EFF = 0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       start = 1'b0;
  logic [2:0] wire_cut = 3'b000;

  logic [1:0] st_o   [2];
  logic [7:0] secs_o [2];
  logic [1:0] strk_o [2];
  logic       pulse_o[2];
  logic       ldef_o [2];
  logic       lexp_o [2];

  int n_checks = 0;
  int n_fail   = 0;

  wire_bomb_ctrl #(.CLK_HZ(CLK_HZ), .TIME_LIMIT_S(TL), .MAX_STRIKES(1),
                   .TARGET_MASK(TGT), .PENALTY_S(PEN)) dut_s1 (
    .CLK(CLK), .RESET(RESET), .start(start), .wire_cut(wire_cut),
    .state(st_o[0]), .seconds_left(secs_o[0]), .strikes(strk_o[0]),
    .strike_pulse(pulse_o[0]), .led_defused(ldef_o[0]), .led_exploded(lexp_o[0]));

  wire_bomb_ctrl #(.CLK_HZ(CLK_HZ), .TIME_LIMIT_S(TL), .MAX_STRIKES(2),
                   .TARGET_MASK(TGT), .PENALTY_S(PEN)) dut_s2 (
    .CLK(CLK), .RESET(RESET), .start(start), .wire_cut(wire_cut),
    .state(st_o[1]), .seconds_left(secs_o[1]), .strikes(strk_o[1]),
    .strike_pulse(pulse_o[1]), .led_defused(ldef_o[1]), .led_exploded(lexp_o[1]));

  always #5 CLK = ~CLK;

  // Reference model: 0=idle 1=armed 2=defused 3=exploded
  int ms[2] = '{1, 2};
  int m_state[2], m_secs[2], m_strikes[2], m_pulse[2];
  int m_mask[2], m_events[2], m_elapsed[2];

  always @(posedge CLK) begin
    int  newb, cand;
    bit  wrong;
    for (int m = 0; m < 2; m++) begin
      if (RESET) begin
        m_state[m] = 0; m_secs[m] = TL; m_strikes[m] = 0; m_pulse[m] = 0;
        m_mask[m] = 0; m_events[m] = 0; m_elapsed[m] = 0;
      end else begin
        m_pulse[m] = 0;
        if (m_state[m] == 0) begin
          if (start && wire_cut == 0) begin
            m_state[m] = 1; m_mask[m] = 0; m_strikes[m] = 0;
            m_events[m] = 0; m_elapsed[m] = 0; m_secs[m] = TL;
          end
        end else if (m_state[m] == 1) begin
          m_elapsed[m]++;
          newb = int'(wire_cut) & ~m_mask[m];
          m_mask[m] = m_mask[m] | int'(wire_cut);
          wrong = (newb & ~int'(TGT)) != 0;
          if (wrong) begin
            m_pulse[m] = 1;
            m_events[m]++;
            if (m_strikes[m] < 3) m_strikes[m]++;
          end
          cand = TL - m_elapsed[m] / CLK_HZ - PEN_EFF * m_events[m];
          if (cand < 0) cand = 0;
          if (wrong && m_strikes[m] >= ms[m]) m_state[m] = 3;
          else if ((m_mask[m] & int'(TGT)) == int'(TGT)) m_state[m] = 2;
          else begin
            m_secs[m] = cand;
            if (cand == 0) m_state[m] = 3;
          end
        end else if (start) begin
          m_state[m] = 0; m_secs[m] = TL; m_strikes[m] = 0;
          m_mask[m] = 0; m_events[m] = 0; m_elapsed[m] = 0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      check_eq($sformatf("m%0d_state", m),   int'(st_o[m]),    m_state[m]);
      check_eq($sformatf("m%0d_secs", m),    int'(secs_o[m]),  m_secs[m]);
      check_eq($sformatf("m%0d_strikes", m), int'(strk_o[m]),  m_strikes[m]);
      check_eq($sformatf("m%0d_pulse", m),   int'(pulse_o[m]), m_pulse[m]);
      check_eq($sformatf("m%0d_led_def", m), int'(ldef_o[m]),  int'(m_state[m] == 2));
      check_eq($sformatf("m%0d_led_exp", m), int'(lexp_o[m]),  int'(m_state[m] == 3));
    end
  endtask

  task automatic cycle(input logic s, input logic [2:0] w, input logic r);
    start = s; wire_cut = w; RESET = r;
    @(posedge CLK);
    @(negedge CLK);
    compare_all();
  endtask

  initial begin
    logic       s, r;
    logic [2:0] w;
    @(negedge CLK);

    // reset values
    cycle(1'b0, 3'b000, 1'b1);
    check_eq("rst_state", int'(st_o[0]), 0);
    check_eq("rst_secs", int'(secs_o[0]), 5);
    check_eq("rst_strikes", int'(strk_o[1]), 0);
    check_eq("rst_leds", int'({ldef_o[0], lexp_o[0]}), 0);

    // basic defuse
    cycle(1'b1, 3'b000, 1'b0);
    check_eq("arm_state", int'(st_o[0]), 1);
    cycle(1'b0, 3'b001, 1'b0);
    repeat (4) cycle(1'b0, 3'b001, 1'b0);
    cycle(1'b0, 3'b101, 1'b0);
    check_eq("defuse_state", int'(st_o[0]), 2);
    check_eq("defuse_led", int'(ldef_o[0]), 1);
    check_eq("defuse_strikes", int'(strk_o[0]), 0);
    check_eq("defuse_secs", int'(secs_o[0]), 5);
    cycle(1'b1, 3'b101, 1'b0);
    check_eq("defused_to_idle", int'(st_o[0]), 0);

    // wrong cut, then toggle of the same wire
    cycle(1'b1, 3'b000, 1'b0);
    cycle(1'b0, 3'b010, 1'b0);
    check_eq("wrong_pulse", int'(pulse_o[1]), 1);
    check_eq("wrong_strikes", int'(strk_o[1]), 1);
    check_eq("wrong_state_s2", int'(st_o[1]), 1);
    check_eq("wrong_state_s1", int'(st_o[0]), 3);
`ifdef STRIKE_TIME_PENALTY_EN
    check_eq("penalty_secs", int'(secs_o[1]), 2);
`endif
    cycle(1'b0, 3'b010, 1'b0);
    check_eq("pulse_one_cycle", int'(pulse_o[1]), 0);
    cycle(1'b0, 3'b000, 1'b0);
    cycle(1'b0, 3'b010, 1'b0);
    check_eq("recut_strikes", int'(strk_o[1]), 1);
    check_eq("recut_pulse", int'(pulse_o[1]), 0);
    cycle(1'b0, 3'b000, 1'b1);

    // timeout
    cycle(1'b1, 3'b000, 1'b0);
    for (int n = 1; n <= 50; n++) begin
      cycle(1'b0, 3'b000, 1'b0);
      check_eq("timeout_secs", int'(secs_o[0]), 5 - n / 10);
      check_eq("timeout_state", int'(st_o[1]), (n == 50) ? 3 : 1);
    end
    check_eq("timeout_led", int'(lexp_o[0]), 1);
    cycle(1'b0, 3'b000, 1'b1);

    // simultaneous cuts
    cycle(1'b1, 3'b000, 1'b0);
    cycle(1'b0, 3'b111, 1'b0);
    check_eq("all_cut_s1", int'(st_o[0]), 3);
    check_eq("all_cut_s2", int'(st_o[1]), 2);
    check_eq("all_cut_strikes", int'(strk_o[1]), 1);
    cycle(1'b0, 3'b000, 1'b1);

    // defuse on the terminal tick
    cycle(1'b1, 3'b000, 1'b0);
    for (int n = 1; n <= 49; n++) cycle(1'b0, 3'b001, 1'b0);
    cycle(1'b0, 3'b101, 1'b0);
    check_eq("race_state", int'(st_o[0]), 2);
    check_eq("race_secs", int'(secs_o[0]), 1);
    cycle(1'b0, 3'b000, 1'b1);

    // mid-countdown reset and blocked arming
    cycle(1'b1, 3'b000, 1'b0);
    repeat (20) cycle(1'b0, 3'b000, 1'b0);
    check_eq("pre_reset_secs", int'(secs_o[0]), 3);
    cycle(1'b0, 3'b000, 1'b1);
    check_eq("mid_reset_state", int'(st_o[0]), 0);
    check_eq("mid_reset_secs", int'(secs_o[0]), 5);
    check_eq("mid_reset_strikes", int'(strk_o[1]), 0);
    cycle(1'b1, 3'b100, 1'b0);
    check_eq("arm_blocked", int'(st_o[0]), 0);
    cycle(1'b0, 3'b000, 1'b0);

    // randomized play against the model
    w = 3'b000;
    repeat (3000) begin
      s = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) w = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) w = 3'b000;
      r = ($urandom_range(0, 299) == 0);
      cycle(s, w, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
